// File: rtl/score_mem_arbiter.sv
// score_mem_arbiter: round-robin sharing of one score RAM read port among voices,
// with a tag pipeline that routes each returned word back to its requester.
module score_mem_arbiter #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1
) (
    input  logic                         CLOCK_50_B5B,
    input  logic                         reset,
    input  logic [NUM_VOICES-1:0]        req,
    input  logic [NUM_VOICES*ADDR_W-1:0] req_addr,
    output logic [NUM_VOICES-1:0]        grant,
    output logic [NUM_VOICES-1:0]        rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic [ADDR_W-1:0]            mem_address,
    input  logic [DATA_W-1:0]            mem_q,
    output logic                         busy
);
    localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;

    logic [IW-1:0]         ptr_q, sel, cand;
    logic                  found;
    logic [ADDR_W-1:0]     sel_addr;
    logic [ADDR_W-1:0]     addr_a [NUM_VOICES];
    logic [NUM_VOICES-1:0] grant_q, rd_valid_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic [ADDR_W-1:0]     mem_address_q;
    // Stage 0 pairs with the registered address; MEM_LAT more stages cover the RAM.
    logic [MEM_LAT:0]      tv_q;
    logic [IW-1:0]         tag_q [MEM_LAT+1];

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++)
            addr_a[v] = req_addr[v*ADDR_W +: ADDR_W];
    end

    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand     = '0;
        sel_addr = '0;
        for (int i = 1; i <= NUM_VOICES; i++) begin
            cand = IW'((int'(ptr_q) + i) % NUM_VOICES);
            if (!found && req[cand]) begin
                found    = 1'b1;
                sel      = cand;
                sel_addr = addr_a[cand];
            end
        end
    end

    always_ff @(posedge CLOCK_50_B5B) begin
        if (reset) begin
            grant_q       <= '0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
            mem_address_q <= '0;
            ptr_q         <= IW'(NUM_VOICES - 1);
            tv_q          <= '0;
        end else begin
            grant_q    <= found ? NUM_VOICES'(1) << sel : '0;
            tv_q       <= {tv_q[MEM_LAT-1:0], found};
            tag_q[0]   <= sel;
            for (int k = 1; k <= MEM_LAT; k++)
                tag_q[k] <= tag_q[k-1];
            rd_valid_q <= tv_q[MEM_LAT] ? NUM_VOICES'(1) << tag_q[MEM_LAT] : '0;
            if (tv_q[MEM_LAT])
                rd_data_q <= mem_q;
            if (found) begin
                mem_address_q <= sel_addr;
                ptr_q         <= sel;
            end
        end
    end

    assign grant       = grant_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_address = mem_address_q;
    assign busy        = |tv_q || |rd_valid_q;
endmodule

// File: tb/tb_score_mem_arbiter.sv
// tb_score_mem_arbiter: two arbiters (MEM_LAT 1 and 3) on shared stimulus, each
// checked every cycle against a round-robin / return-schedule model.
module tb_score_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [1:0][N-1:0] grant, rd_valid;
    logic [1:0][DW-1:0] rd_data, mem_q;
    logic [1:0][AW-1:0] mem_address;
    logic [1:0] busy;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int L = d ? 3 : 1;
        logic [AW-1:0] hist [L];
        always @(posedge clk) begin
            hist[0] <= mem_address[d];
            for (int j = 1; j < L; j++) hist[j] <= hist[j-1];
        end
        assign mem_q[d] = DW'(hist[L-1]) + 16'h1000;
        score_mem_arbiter #(.NUM_VOICES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
            .CLOCK_50_B5B(clk), .reset(reset), .req(req), .req_addr(req_addr),
            .grant(grant[d]), .rd_valid(rd_valid[d]), .rd_data(rd_data[d]),
            .mem_address(mem_address[d]), .mem_q(mem_q[d]), .busy(busy[d])
        );
    end

    int checks = 0;
    int errors = 0;
    int ptr = N - 1;
    int cyc = 0;
    int slot_v [2][16];
    logic [DW-1:0] slot_d [2][16];
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_rd [2];
    logic [N-1:0] last_grant = '0;

    function automatic int lat(int d);
        return d ? 3 : 1;
    endfunction

    // One clock of the reference model: RR choice from req, then scheduled returns.
    task automatic step();
        int g, ev, s;
        logic [AW-1:0] a;
        logic [N-1:0] erv;
        logic eb;
        g = -1;
        a = '0;
        if (!reset)
            for (int i = 1; i <= N; i++)
                if (g < 0 && req[(ptr + i) % N]) g = (ptr + i) % N;
        if (g >= 0) a = req_addr[g*AW +: AW];
        @(posedge clk);
        #1;
        cyc++;
        last_grant = '0;
        if (reset) begin
            ptr = N - 1;
            exp_addr = '0;
            for (int d = 0; d < 2; d++) begin
                exp_rd[d] = '0;
                for (int k = 0; k < 16; k++) slot_v[d][k] = -1;
            end
        end else if (g >= 0) begin
            ptr = g;
            exp_addr = a;
            last_grant[g] = 1'b1;
            for (int d = 0; d < 2; d++) begin
                s = (cyc + lat(d) + 1) % 16;
                slot_v[d][s] = g;
                slot_d[d][s] = DW'(a) + 16'h1000;
            end
        end
        for (int d = 0; d < 2; d++) begin
            s = cyc % 16;
            ev = slot_v[d][s];
            erv = ev >= 0 ? N'(1) << ev : '0;
            if (ev >= 0) exp_rd[d] = slot_d[d][s];
            eb = 1'b0;
            for (int k = 0; k < 16; k++) if (slot_v[d][k] >= 0) eb = 1'b1;
            slot_v[d][s] = -1;
            checks += 5;
            if (grant[d] !== last_grant) begin
                errors++;
                $display("FAIL grant lat%0d cyc %0d got %b exp %b", lat(d), cyc, grant[d], last_grant);
            end
            if (mem_address[d] !== exp_addr) begin
                errors++;
                $display("FAIL mem_address lat%0d cyc %0d got %h exp %h", lat(d), cyc, mem_address[d], exp_addr);
            end
            if (rd_valid[d] !== erv) begin
                errors++;
                $display("FAIL rd_valid lat%0d cyc %0d got %b exp %b", lat(d), cyc, rd_valid[d], erv);
            end
            if (rd_data[d] !== exp_rd[d]) begin
                errors++;
                $display("FAIL rd_data lat%0d cyc %0d got %h exp %h", lat(d), cyc, rd_data[d], exp_rd[d]);
            end
            if (busy[d] !== eb) begin
                errors++;
                $display("FAIL busy lat%0d cyc %0d got %b exp %b", lat(d), cyc, busy[d], eb);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drain(int n);
        req = '0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        req = '1;
        reset = 1'b1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (grant[d] !== '0 || rd_valid[d] !== '0 || rd_data[d] !== '0 || mem_address[d] !== '0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state lat%0d got g=%b v=%b d=%h a=%h b=%b exp all zero",
                         lat(d), grant[d], rd_valid[d], rd_data[d], mem_address[d], busy[d]);
            end
        end
        reset = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        req_addr = '0;
        req_addr[0 +: AW] = 10'h005;
        step();
        checks++;
        if (grant[0] !== 4'b0001 || mem_address[0] !== 10'h005) begin
            errors++;
            $display("FAIL single_grant got g=%b a=%h exp g=0001 a=005", grant[0], mem_address[0]);
        end
        req = '0;
        step();
        step();
        checks++;
        if (rd_valid[0] !== 4'b0001 || rd_data[0] !== 16'h1005) begin
            errors++;
            $display("FAIL single_return got v=%b d=%h exp v=0001 d=1005", rd_valid[0], rd_data[0]);
        end
        drain(4);
    endtask

    task automatic test_all_req();
        do_reset();
        req = '1;
        for (int v = 0; v < N; v++) req_addr[v*AW +: AW] = AW'($urandom);
        for (int i = 0; i < 8; i++) begin
            step();
            for (int v = 0; v < N; v++) if (last_grant[v]) req_addr[v*AW +: AW] = AW'($urandom);
            checks++;
            if (grant[0] !== N'(1) << (i % N)) begin
                errors++;
                $display("FAIL all_req_order step %0d got %b exp %b", i, grant[0], N'(1) << (i % N));
            end
            if (i >= 2) begin
                checks++;
                if (rd_valid[0] !== N'(1) << ((i - 2) % N)) begin
                    errors++;
                    $display("FAIL all_req_return step %0d got %b exp %b", i, rd_valid[0], N'(1) << ((i - 2) % N));
                end
            end
        end
        drain(5);
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0011;
        step();
        checks++;
        if (grant[0] !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_first got %b exp 0001", grant[0]);
        end
        step();
        checks++;
        if (grant[0] !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_second got %b exp 0010", grant[0]);
        end
        drain(5);
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0011;
        step();
        req = 4'b0001;
        step();
        req = '0;
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (grant[d][1] !== 1'b0 || rd_valid[d][1] !== 1'b0) begin
                    errors++;
                    $display("FAIL withdraw lat%0d step %0d got g=%b v=%b exp voice1 idle", lat(d), i, grant[d], rd_valid[d]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        step();
        req = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || mem_address[d] !== '0) begin
                errors++;
                $display("FAIL reset_mid lat%0d got b=%b a=%h exp b=0 a=000", lat(d), busy[d], mem_address[d]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd_valid[d] !== '0) begin
                    errors++;
                    $display("FAIL reset_flush lat%0d step %0d got %b exp 0000", lat(d), i, rd_valid[d]);
                end
            end
        end
    endtask

    task automatic test_lat3();
        do_reset();
        req = 4'b0101;
        for (int v = 0; v < N; v++) req_addr[v*AW +: AW] = AW'($urandom);
        for (int i = 0; i < 12; i++) begin
            step();
            for (int v = 0; v < N; v++) if (last_grant[v]) req_addr[v*AW +: AW] = AW'($urandom);
            if (i >= 4) begin
                checks++;
                if (rd_valid[1] !== (i % 2 == 0 ? 4'b0001 : 4'b0100)) begin
                    errors++;
                    $display("FAIL lat3_alternate step %0d got %b exp %b", i, rd_valid[1], i % 2 == 0 ? 4'b0001 : 4'b0100);
                end
            end
        end
        drain(6);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int v = 0; v < N; v++) begin
                if (req[v] && !last_grant[v]) begin
                    if ($urandom_range(9) == 0) req[v] = 1'b0;
                end else begin
                    req[v] = 1'($urandom_range(1));
                    req_addr[v*AW +: AW] = AW'($urandom);
                end
            end
            step();
        end
        drain(6);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = '0;
            for (int k = 0; k < 16; k++) slot_v[d][k] = -1;
        end
        test_reset();
        test_single();
        test_all_req();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        test_lat3();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
